// File: rtl/trace_checker_pkg.sv
// Shared types for the trace checker: FSM states, error codes and FIFO entry layout.
package trace_checker_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StPass,
    StFail
  } state_e;

  localparam logic [1:0] ErrNone    = 2'd0;
  localparam logic [1:0] ErrAddr    = 2'd1;
  localparam logic [1:0] ErrData    = 2'd2;
  localparam logic [1:0] ErrTimeout = 2'd3;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic        dc;
  } entry_t;

endpackage

// File: rtl/trace_checker_if.sv
// Load, trace and status signals of the trace checker grouped as one bundle.
interface trace_checker_if #(
  parameter int unsigned DEPTH = 16
);
  localparam int unsigned IdxW = $clog2(DEPTH);

  logic            load_val;
  logic [31:0]     load_addr;
  logic [31:0]     load_data;
  logic            load_dc;
  logic            load_rdy;
  logic            start;
  logic            trace_val;
  logic [31:0]     trace_addr;
  logic [31:0]     trace_data;
  logic            busy;
  logic            pass;
  logic            fail;
  logic [1:0]      err_code;
  logic [IdxW-1:0] err_idx;
  logic [31:0]     cycles;

  modport master (
    output load_val, load_addr, load_data, load_dc, start, trace_val, trace_addr, trace_data,
    input  load_rdy, busy, pass, fail, err_code, err_idx, cycles
  );

  modport slave (
    input  load_val, load_addr, load_data, load_dc, start, trace_val, trace_addr, trace_data,
    output load_rdy, busy, pass, fail, err_code, err_idx, cycles
  );

endinterface

// File: rtl/trace_fifo.sv
// Synchronous FIFO of expected trace entries; head is read combinationally.
module trace_fifo
  import trace_checker_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic   clk_i,
  input  logic   rst_ni,
  input  logic   push_i,
  input  entry_t push_data_i,
  input  logic   pop_i,
  output entry_t head_o,
  output logic   full_o,
  output logic   empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PtrOne = (AW + 1)'(1);

  // Extra MSB on each pointer distinguishes full from empty.
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  entry_t      mem_q [DEPTH];

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_i && !full_o) wr_ptr_d = wr_ptr_q + PtrOne;
    if (pop_i && !empty_o) rd_ptr_d = rd_ptr_q + PtrOne;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i && !full_o) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
  end

endmodule

// File: rtl/trace_checker.sv
// Compares a retired-instruction trace against a preloaded expected sequence.
// Optional idle timeout enabled by defining TRACE_CHECKER_TIMEOUT_EN.
module trace_checker
  import trace_checker_pkg::*;
#(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  trace_checker_if.slave bus
);

  localparam int unsigned IdxW   = $clog2(DEPTH);
  localparam logic [IdxW-1:0] IdxOne = IdxW'(1);

  if (DEPTH < 2 || DEPTH > 256 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1 || TIMEOUT > 65535)
  begin : g_param_check
    $error("trace_checker: DEPTH or TIMEOUT out of range");
  end

  state_e          state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [31:0]     cycles_q, cycles_d;
  logic [1:0]      err_code_q, err_code_d;
  logic [IdxW-1:0] err_idx_q, err_idx_d;

`ifdef TRACE_CHECKER_TIMEOUT_EN
  localparam logic [15:0] TimeoutVal = 16'(TIMEOUT);
  logic [15:0] idle_q, idle_d;
`endif

  entry_t head, push_entry;
  logic   fifo_full, fifo_empty, pop;

  assign push_entry = '{addr: bus.load_addr, data: bus.load_data, dc: bus.load_dc};

  trace_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .push_i     (bus.load_val && bus.load_rdy),
    .push_data_i(push_entry),
    .pop_i      (pop),
    .head_o     (head),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cycles_d   = cycles_q;
    err_code_d = err_code_q;
    err_idx_d  = err_idx_q;
    pop        = 1'b0;
`ifdef TRACE_CHECKER_TIMEOUT_EN
    idle_d     = idle_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (bus.start) state_d = StRun;
      end
      StRun: begin
        cycles_d = cycles_q + 32'd1;
`ifdef TRACE_CHECKER_TIMEOUT_EN
        idle_d = bus.trace_val ? 16'd0 : idle_q + 16'd1;
`endif
        if (fifo_empty) begin
          state_d = StPass;
        end
`ifdef TRACE_CHECKER_TIMEOUT_EN
        else if (idle_q == TimeoutVal) begin
          state_d    = StFail;
          err_code_d = ErrTimeout;
          err_idx_d  = idx_q;
        end
`endif
        else if (bus.trace_val) begin
          // Address mismatch outranks data mismatch.
          if (head.addr != bus.trace_addr) begin
            state_d    = StFail;
            err_code_d = ErrAddr;
            err_idx_d  = idx_q;
          end else if (!head.dc && head.data != bus.trace_data) begin
            state_d    = StFail;
            err_code_d = ErrData;
            err_idx_d  = idx_q;
          end else begin
            pop   = 1'b1;
            idx_d = idx_q + IdxOne;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      cycles_q   <= '0;
      err_code_q <= ErrNone;
      err_idx_q  <= '0;
`ifdef TRACE_CHECKER_TIMEOUT_EN
      idle_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cycles_q   <= cycles_d;
      err_code_q <= err_code_d;
      err_idx_q  <= err_idx_d;
`ifdef TRACE_CHECKER_TIMEOUT_EN
      idle_q     <= idle_d;
`endif
    end
  end

  assign bus.load_rdy = (state_q == StIdle) && !fifo_full;
  assign bus.busy     = (state_q == StRun);
  assign bus.pass     = (state_q == StPass);
  assign bus.fail     = (state_q == StFail);
  assign bus.err_code = err_code_q;
  assign bus.err_idx  = err_idx_q;
  assign bus.cycles   = cycles_q;

endmodule
